// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the pipelined add/subtract unit.
package adder_pkg;

   function automatic int chunk_w(input int width, input int stages);
      return (stages < 1) ? width : width / stages;
   endfunction

   // Per-slot control: carry into this slot's chunk and the slot's valid bit.
   typedef struct packed {
      logic c;
      logic v;
   } stage_ctl_t;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

endpackage

// File: rtl/adder_chunk.sv
// C-bit combinational add slice with carry in and carry out.
module adder_chunk #(
   parameter int C = 8
) (
   input  logic [C-1:0] a,
   input  logic [C-1:0] b,
   input  logic         cin,
   output logic [C-1:0] s,
   output logic         co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready handshake and NZCV-style flags.
// Slot k adds chunk k; finished chunks overwrite the a-operand bits as the beat moves down.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int C = chunk_w(WIDTH, STAGES);

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   stage_ctl_t       ctl [STAGES];
   logic [WIDTH-1:0] x   [STAGES];  // sum chunks below k, a chunks from k up
   logic [WIDTH-1:0] y   [STAGES];  // b' (already inverted for subtract)
   logic [C-1:0]     s   [STAGES];
   logic             co  [STAGES];
   logic             adv;
   logic [WIDTH-1:0] res;
   flags_t           flags;

   assign adv       = !ctl[STAGES-1].v || out_ready;
   assign in_ready  = adv;
   assign out_valid = ctl[STAGES-1].v;

   for (genvar k = 0; k < STAGES; k++) begin : g_chunk
      adder_chunk #(.C(C)) u_chunk (
         .a  (x[k][k*C +: C]),
         .b  (y[k][k*C +: C]),
         .cin(ctl[k].c),
         .s  (s[k]),
         .co (co[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) ctl[k] <= '0;
      end else if (adv) begin
         ctl[0].v <= in_valid;
         if (in_valid) ctl[0].c <= sub | cin;
         for (int k = 1; k < STAGES; k++) begin
            ctl[k].v <= ctl[k-1].v;
            ctl[k].c <= co[k-1];
         end
      end
   end

   // Datapath needs no reset: outputs are masked by out_valid.
   always_ff @(posedge clk) begin
      if (adv) begin
         if (in_valid) begin
            x[0] <= a;
            y[0] <= sub ? ~b : b;
         end
         for (int k = 1; k < STAGES; k++) begin
            x[k]                <= x[k-1];
            x[k][(k-1)*C +: C]  <= s[k-1];
            y[k]                <= y[k-1];
         end
      end
   end

   always_comb begin
      res                        = x[STAGES-1];
      res[(STAGES-1)*C +: C]     = s[STAGES-1];
      flags.cout = co[STAGES-1];
      flags.ovf  = (x[STAGES-1][WIDTH-1] == y[STAGES-1][WIDTH-1]) &&
                   (res[WIDTH-1] != x[STAGES-1][WIDTH-1]);
      flags.zero = ~|res;
      flags.neg  = res[WIDTH-1];
   end

   assign sum                     = out_valid ? res : '0;
   assign {cout, ovf, zero, neg}  = out_valid ? flags : '0;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: three configurations (32/4, 32/1, 64/8) against an arithmetic reference model.
module tb_pipelined_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic        iv   [3];
   logic        ordy [3];
   logic [63:0] ai   [3];
   logic [63:0] bi   [3];
   logic        subi [3];
   logic        cini [3];
   logic        ir   [3];
   logic        ov   [3];
   logic        cf   [3];
   logic        vf   [3];
   logic        zf   [3];
   logic        nf   [3];
   logic [31:0] s0, s1;
   logic [63:0] s2;
   logic [63:0] so   [3];

   assign so[0] = {32'b0, s0};
   assign so[1] = {32'b0, s1};
   assign so[2] = s2;

   pipelined_adder #(.WIDTH(32), .STAGES(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(ai[0][31:0]), .b(bi[0][31:0]), .sub(subi[0]), .cin(cini[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0),
      .cout(cf[0]), .ovf(vf[0]), .zero(zf[0]), .neg(nf[0]));

   pipelined_adder #(.WIDTH(32), .STAGES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(ai[1][31:0]), .b(bi[1][31:0]), .sub(subi[1]), .cin(cini[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1),
      .cout(cf[1]), .ovf(vf[1]), .zero(zf[1]), .neg(nf[1]));

   pipelined_adder #(.WIDTH(64), .STAGES(8)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(ai[2]), .b(bi[2]), .sub(subi[2]), .cin(cini[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2),
      .cout(cf[2]), .ovf(vf[2]), .zero(zf[2]), .neg(nf[2]));

   function automatic int wof(input int d);
      return (d == 2) ? 64 : 32;
   endfunction

   function automatic int sof(input int d);
      case (d)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic [67:0] obs(input int d);
      return {cf[d], vf[d], zf[d], nf[d], so[d]};
   endfunction

   // Reference: unsigned wrap for sum/cout, exact signed arithmetic for overflow.
   function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic sub, input logic cin);
      logic [64:0]        one, msk, ua, ub, tot;
      logic signed [66:0] onex, sa, sb, ex, hi, lo;
      logic               c, v;
      one  = 65'd1 << w;
      msk  = one - 65'd1;
      ua   = {1'b0, a} & msk;
      ub   = {1'b0, b} & msk;
      onex = $signed({2'b00, one});
      sa   = $signed({2'b00, ua});
      sb   = $signed({2'b00, ub});
      if (ua[w-1]) sa = sa - onex;
      if (ub[w-1]) sb = sb - onex;
      hi = (onex >>> 1) - 67'sd1;
      lo = -(onex >>> 1);
      if (sub) begin
         ex  = sa - sb;
         tot = (ua - ub) & msk;
         c   = (ua >= ub);
      end else begin
         ex  = sa + sb + $signed({66'b0, cin});
         tot = ua + ub + {64'b0, cin};
         c   = (tot >= one);
         tot = tot & msk;
      end
      v = (ex > hi) || (ex < lo);
      return {c, v, (tot == 65'd0), tot[w-1], tot[63:0]};
   endfunction

   task automatic send_and_wait(input int d, input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input logic cin,
                                output int lat, output logic [67:0] o);
      @(negedge clk);
      ai[d] = a; bi[d] = b; subi[d] = sub; cini[d] = cin;
      iv[d] = 1'b1; ordy[d] = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      iv[d] = 1'b0;
      while (!ov[d] && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      o = obs(d);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         total++;
         if (ov[d] !== 1'b0) $display("FAIL reset_out_valid[%0d] got %b want 0", d, ov[d]);
         else passed++;
         total++;
         if (obs(d) !== 68'd0) $display("FAIL reset_outputs[%0d] got %h want 0", d, obs(d));
         else passed++;
         total++;
         if (ir[d] !== 1'b1) $display("FAIL reset_in_ready[%0d] got %b want 1", d, ir[d]);
         else passed++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed(input int d);
      logic [63:0] ta [6];
      logic [63:0] tb_ [6];
      logic        ts [6];
      logic        tc [6];
      logic [67:0] k32 [6];
      logic [67:0] o, e;
      int          lat;
      ta[0] = 64'hFF;       tb_[0] = 64'h1; ts[0] = 0; tc[0] = 0; k32[0] = {4'b0000, 64'h100};
      ta[1] = 64'hFFFFFFFF; tb_[1] = 64'h1; ts[1] = 0; tc[1] = 0; k32[1] = {4'b1010, 64'h0};
      ta[2] = 64'h7FFFFFFF; tb_[2] = 64'h1; ts[2] = 0; tc[2] = 0; k32[2] = {4'b0101, 64'h80000000};
      ta[3] = 64'h5;        tb_[3] = 64'h7; ts[3] = 1; tc[3] = 0; k32[3] = {4'b0001, 64'hFFFFFFFE};
      ta[4] = 64'h7;        tb_[4] = 64'h5; ts[4] = 1; tc[4] = 1; k32[4] = {4'b1000, 64'h2};
      ta[5] = 64'h1;        tb_[5] = 64'h1; ts[5] = 0; tc[5] = 1; k32[5] = {4'b0000, 64'h3};
      for (int i = 0; i < 6; i++) begin
         send_and_wait(d, ta[i], tb_[i], ts[i], tc[i], lat, o);
         total++;
         if (lat !== sof(d)) $display("FAIL latency[%0d] case %0d got %0d want %0d", d, i, lat, sof(d));
         else passed++;
         e = model(wof(d), ta[i], tb_[i], ts[i], tc[i]);
         total++;
         if (o !== e) $display("FAIL directed_model[%0d] case %0d got %h want %h", d, i, o, e);
         else passed++;
         if (wof(d) == 32) begin
            total++;
            if (o !== k32[i]) $display("FAIL directed_const[%0d] case %0d got %h want %h", d, i, o, k32[i]);
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back(input int d);
      logic [67:0] q [$];
      logic [67:0] held, e;
      logic        was_stalled, acc, pop;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0; was_stalled = 0; held = '0;
      while (got < 16 && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (was_stalled) begin
            total++;
            if (ov[d] !== 1'b1 || obs(d) !== held)
               $display("FAIL stall_hold[%0d] got %b/%h want 1/%h", d, ov[d], obs(d), held);
            else passed++;
         end
         ordy[d] = 1'($urandom_range(0, 1));
         if (sent < 16) begin
            iv[d]   = ($urandom_range(0, 3) != 0);
            ai[d]   = {$urandom, $urandom};
            bi[d]   = {$urandom, $urandom};
            subi[d] = 1'($urandom_range(0, 1));
            cini[d] = 1'($urandom_range(0, 1));
         end else iv[d] = 1'b0;
         #1;
         total++;
         if (ir[d] !== (!ov[d] || ordy[d]))
            $display("FAIL in_ready[%0d] got %b want %b", d, ir[d], (!ov[d] || ordy[d]));
         else passed++;
         acc = iv[d] && ir[d];
         pop = ov[d] && ordy[d];
         if (pop) begin
            total++;
            if (q.size() == 0) $display("FAIL b2b_extra[%0d] got %h want none", d, obs(d));
            else begin
               e = q.pop_front();
               if (obs(d) !== e) $display("FAIL b2b_result[%0d] beat %0d got %h want %h", d, got, obs(d), e);
               else passed++;
            end
            got++;
         end
         if (acc) begin
            q.push_back(model(wof(d), ai[d], bi[d], subi[d], cini[d]));
            sent++;
         end
         was_stalled = ov[d] && !ordy[d];
         held = obs(d);
      end
      @(negedge clk);
      iv[d] = 1'b0; ordy[d] = 1'b1;
      total++;
      if (got !== 16 || q.size() != 0)
         $display("FAIL b2b_count[%0d] got %0d left %0d want 16 left 0", d, got, q.size());
      else passed++;
   endtask

   task automatic test_reset_inflight(input int d);
      logic [63:0] a, b;
      logic [67:0] o, e;
      int          lat;
      @(negedge clk);
      ordy[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[d] = 1'b1; subi[d] = 1'b0; cini[d] = 1'b0;
         ai[d] = {$urandom, $urandom}; bi[d] = {$urandom, $urandom};
         @(negedge clk);
      end
      iv[d] = 1'b0;
      repeat (sof(d)) @(negedge clk);
      total++;
      if (ov[d] !== 1'b1) $display("FAIL inflight_stalled[%0d] got %b want 1", d, ov[d]);
      else passed++;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (ov[d] !== 1'b0 || obs(d) !== 68'd0 || ir[d] !== 1'b1)
         $display("FAIL inflight_reset[%0d] got v=%b o=%h r=%b want 0/0/1", d, ov[d], obs(d), ir[d]);
      else passed++;
      rst_n = 1'b1;
      a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
      send_and_wait(d, a, b, 1'b1, 1'b0, lat, o);
      e = model(wof(d), a, b, 1'b1, 1'b0);
      total++;
      if (lat !== sof(d) || o !== e)
         $display("FAIL after_reset[%0d] got lat %0d %h want lat %0d %h", d, lat, o, sof(d), e);
      else passed++;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         iv[d] = 0; ordy[d] = 1; ai[d] = '0; bi[d] = '0; subi[d] = 0; cini[d] = 0;
      end
      test_reset();
      for (int d = 0; d < 3; d++) test_directed(d);
      for (int d = 0; d < 3; d++) test_back_to_back(d);
      test_reset_inflight(0);
      test_reset_inflight(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined integer add/subtract unit with a valid/ready handshake. It is the multi-cycle successor to the single-cycle 32-bit adder: configurable width and pipeline depth, a subtract mode, a carry-in, and NZCV-style flags. It sits in the EX stage datapath for wide or high-frequency builds, where a single-cycle ripple adder limits fmax.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth, ≥1; each stage adds one WIDTH/STAGES-bit chunk.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- a, b  in  WIDTH  operands.
- sub  in  1  0: a+b+cin; 1: a−b computed as a+~b+1 (cin ignored).
- cin  in  1  carry-in for add mode.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

## Operation
- Chunk width C = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*C +: C] of a and b' (b' = sub ? ~b : b) plus a carry: stage 0 takes sub ? 1 : cin; stage k>0 takes the registered carry from stage k−1.
- Unprocessed upper operand chunks travel down the pipeline with the beat (skew registers); finished lower sum chunks travel down with it (deskew). Each stage holds a valid bit.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage shifts forward one slot, and stage 0 captures a/b/sub/cin if in_valid. When adv=0, all stages hold.
- in_ready = adv. A beat is accepted iff in_valid && in_ready.
- Flags are formed in the final stage from the full result: ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]); zero = ~|sum; neg = sum[MSB]; cout = final chunk carry.
- Results leave in acceptance order. No reordering, no drop, no duplication.
- STAGES=1 degenerates to a single registered adder with the same handshake.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (visible in cycle N+STAGES), provided no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, sum and flags hold stable and in_ready=0 in that same cycle (combinational from out_ready). Bubbles do not collapse; the pipeline is a rigid shift.
- in_valid may drop at any time. Data is sampled only on accept.
- Simultaneous output pop and input push: both take effect on the same edge.
- Reset (rst_n=0 at an edge): all stage valid bits, out_valid, sum, cout, ovf, zero and neg go to 0, and in-flight beats are discarded. in_ready=1 in the first cycle after reset. Reset mid-stall has the same effect.
- Wrap-around: the modulo-2^WIDTH result is reported, with overflow shown only through cout/ovf.

## Structure
- Shared package adder_pkg: localparam helper for C; typedef for the per-stage carry/valid bundle; flag struct {cout, ovf, zero, neg}.
- Sub-module adder_chunk (C-bit combinational slice: a, b, cin → s, co), instantiated STAGES times via generate.
- Elaboration-time check: WIDTH % STAGES == 0 and STAGES ≥ 1, otherwise $fatal.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1. Add 0x0000_00FF + 0x0000_0001 → sum 0x0000_0100, cout 0, ovf 0, out_valid exactly 4 cycles after accept.
- Carry across every chunk: 0xFFFF_FFFF + 0x0000_0001 → sum 0, cout 1, zero 1, ovf 0. Then 0x7FFF_FFFF + 1 → 0x8000_0000, ovf 1, neg 1.
- Subtract: sub=1, 5 − 7 → 0xFFFF_FFFE, cout 0, neg 1. Then sub=1, 7 − 5 → 2, cout 1. Then add with cin=1, 1+1 → 3.
- Back-to-back stream of 16 random beats with out_ready toggling randomly. Every result must match the golden model in order, with none lost or duplicated, and sum must hold stable while stalled.
- Reset asserted with 3 beats in flight and out_ready=0 → next cycle out_valid=0, all outputs 0, in_ready=1. A fresh beat afterwards returns the correct result.
- Re-run the directed cases at STAGES=1 (latency 1) and at WIDTH=64, STAGES=8 (latency 8).
